// File: rtl/ex_weight_row_loader.sv
// ex_weight_row_loader: packs a serial stream of signed weights into LANES-wide rows
// and writes each row into the expansion weight memory at base_index+row.
`default_nettype none

module ex_weight_row_loader #(
  parameter int DATA_WIDTH = 14,
  parameter int LANES      = 256,
  parameter int HEIGHT     = 938,
  parameter int IDX_W      = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic [IDX_W-1:0]              base_index,
  input  logic [IDX_W-1:0]              num_rows,
  input  logic                          s_valid,
  input  logic [DATA_WIDTH-1:0]         s_data,
  output logic                          s_ready,
  output logic [LANES*DATA_WIDTH-1:0]   mem_data,
  output logic [IDX_W-1:0]              mem_index,
  output logic                          mem_en,
  output logic                          mem_wr,
  output logic                          mem_rd,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [IDX_W:0]    HEIGHT_L    = (IDX_W+1)'(HEIGHT);
  localparam logic [LANE_W-1:0] LAST_LANE   = LANE_W'(LANES - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE     = IDX_W'(1);

  logic [1:0]                   state;
  logic [LANES*DATA_WIDTH-1:0]  row_buf;
  logic [LANE_W-1:0]            lane_cnt;
  logic [IDX_W-1:0]             row_cnt;
  logic [IDX_W-1:0]             base_r;
  logic [IDX_W-1:0]             num_r;
  logic [IDX_W-1:0]             index_r;
  logic                         err_r;

  logic [IDX_W:0]               end_row;
  logic                         start_ok;
  logic                         last_lane;
  logic                         last_row;

  // Extra bit on the sum so a job running past the top of the index space is caught
  assign end_row   = {1'b0, base_index} + {1'b0, num_rows};
  assign start_ok  = (num_rows != '0) && (end_row <= HEIGHT_L);
  assign last_lane = (lane_cnt == LAST_LANE);
  assign last_row  = (row_cnt == (num_r - IDX_ONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      row_buf  <= '0;
      lane_cnt <= '0;
      row_cnt  <= '0;
      base_r   <= '0;
      num_r    <= '0;
      index_r  <= '0;
      err_r    <= 1'b0;
    end else begin
      err_r <= 1'b0;
      if (abort) begin
        state    <= S_IDLE;
        lane_cnt <= '0;
        row_cnt  <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              if (start_ok) begin
                base_r   <= base_index;
                num_r    <= num_rows;
                lane_cnt <= '0;
                row_cnt  <= '0;
                state    <= S_FILL;
              end else begin
                err_r <= 1'b1;
              end
            end
          end
          S_FILL: begin
            if (s_valid) begin
              row_buf[lane_cnt*DATA_WIDTH +: DATA_WIDTH] <= s_data;
              if (last_lane) begin
                lane_cnt <= '0;
                index_r  <= base_r + row_cnt;
                state    <= S_WRITE;
              end else begin
                lane_cnt <= lane_cnt + LANE_W'(1);
              end
            end
          end
          S_WRITE: begin
            if (last_row) begin
              state <= S_DONE;
            end else begin
              row_cnt <= row_cnt + IDX_ONE;
              state   <= S_FILL;
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // abort also suppresses a write or done that would otherwise show in this same cycle
  assign s_ready   = (state == S_FILL);
  assign mem_en    = (state == S_WRITE) && !abort;
  assign mem_wr    = (state == S_WRITE) && !abort;
  assign mem_rd    = 1'b0;
  assign busy      = (state == S_FILL) || (state == S_WRITE);
  assign done      = (state == S_DONE) && !abort;
  assign err       = err_r;
  assign mem_data  = row_buf;
  assign mem_index = index_r;

endmodule

`default_nettype wire

// File: tb/tb_ex_weight_row_loader.sv
// tb_ex_weight_row_loader: randomized stimulus against a job-level behavioural model,
// compared every cycle, plus literal checks that pin the model.
`default_nettype none

module tb_ex_weight_row_loader;
  localparam int DW = 14, LANES = 256, HEIGHT = 938, IDX_W = 10;

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, abort = 1'b0, s_valid = 1'b0;
  logic [IDX_W-1:0] base_index = '0, num_rows = '0;
  logic [DW-1:0] s_data = '0;
  logic s_ready, mem_en, mem_wr, mem_rd, busy, done, err;
  logic [LANES*DW-1:0] mem_data;
  logic [IDX_W-1:0] mem_index;

  ex_weight_row_loader #(.DATA_WIDTH(DW), .LANES(LANES), .HEIGHT(HEIGHT), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .base_index(base_index),
    .num_rows(num_rows), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .mem_data(mem_data), .mem_index(mem_index), .mem_en(mem_en), .mem_wr(mem_wr),
    .mem_rd(mem_rd), .busy(busy), .done(done), .err(err));

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model (job level) ----------------
  bit m_active, m_wr, m_done, m_err;
  int m_beats, m_rows, m_base, m_num;
  logic [IDX_W-1:0] m_idx;
  logic [DW-1:0] m_words [LANES];

  function automatic logic [LANES*DW-1:0] packed_row();
    logic [LANES*DW-1:0] v;
    for (int k = 0; k < LANES; k++) v[k*DW +: DW] = m_words[k];
    return v;
  endfunction

  // observation records taken from the DUT for literal checks
  int cyc = 0, wr_count = 0, err_count = 0, done_count = 0;
  int wr_cyc = 0, done_cyc = 0, acc_cyc = 0;
  logic [IDX_W-1:0] last_wr_index;
  logic [LANES*DW-1:0] last_wr_data;

  always @(negedge clk) begin
    logic e_ready, e_wr, e_done, e_busy, e_err;
    logic [IDX_W-1:0] e_idx;
    bit n_done, n_err;
    cyc++;
    if (rst) begin
      {e_ready, e_wr, e_done, e_busy, e_err} = '0;
      e_idx = '0;
    end else begin
      e_ready = m_active && !m_wr;
      e_wr    = m_wr && !abort;
      e_done  = m_done && !abort;
      e_busy  = m_active;
      e_err   = m_err;
      e_idx   = m_idx;
    end
    chk("s_ready", s_ready, e_ready);
    chk("mem_en", mem_en, e_wr);
    chk("mem_wr", mem_wr, e_wr);
    chk("mem_rd", mem_rd, 1'b0);
    chk("done", done, e_done);
    chk("busy", busy, e_busy);
    chk("err", err, e_err);
    chk("mem_index", mem_index, e_idx);
    if (rst) begin
      n_checks++;
      if (mem_data !== '0) begin n_fail++; $display("FAIL reset_mem_data: got nonzero expected 0"); end
    end
    if (e_wr) begin
      n_checks++;
      if (mem_data !== packed_row()) begin
        n_fail++;
        $display("FAIL row_data idx %0d: got %0h.. expected %0h..", e_idx, mem_data[63:0], packed_row() & 64'hFFFFFFFFFFFFFFFF);
      end
    end
    if (mem_wr) begin wr_count++; last_wr_index = mem_index; last_wr_data = mem_data; wr_cyc = cyc; end
    if (done) begin done_count++; done_cyc = cyc; end
    if (err) err_count++;
    if (!rst && !abort && e_ready && s_valid && m_beats == 0 && m_rows == 0) acc_cyc = cyc;

    // advance the model with the inputs the DUT will sample at the next rising edge
    if (rst) begin
      m_active = 0; m_wr = 0; m_done = 0; m_err = 0; m_beats = 0; m_rows = 0; m_idx = '0;
    end else if (abort) begin
      m_active = 0; m_wr = 0; m_done = 0; m_err = 0; m_beats = 0; m_rows = 0;
    end else begin
      n_done = 0; n_err = 0;
      if (m_wr) begin
        m_wr = 0;
        m_rows++;
        if (m_rows == m_num) begin m_active = 0; n_done = 1; end
      end else if (m_active) begin
        if (s_valid) begin
          m_words[m_beats] = s_data;
          m_beats++;
          if (m_beats == LANES) begin
            m_beats = 0;
            m_wr = 1;
            m_idx = IDX_W'(m_base + m_rows);
          end
        end
      end else if (!m_done && start) begin
        if (num_rows != 0 && int'(base_index) + int'(num_rows) <= HEIGHT) begin
          m_active = 1; m_base = int'(base_index); m_num = int'(num_rows);
          m_rows = 0; m_beats = 0;
        end else begin
          n_err = 1;
        end
      end
      m_done = n_done; m_err = n_err;
    end
  end

  // ---------------- stream driver ----------------
  int valid_pct = 100;
  int data_mode = 0;  // 0 random, 1 lane index, 2 negative-extremes pattern

  always @(posedge clk) begin
    #1;
    s_valid = ($urandom_range(99) < valid_pct);
    case (data_mode)
      1: s_data = DW'(m_beats);
      2: s_data = (m_beats == 0) ? 14'h3FFF : (m_beats == LANES-1) ? 14'h2000 : DW'($urandom);
      default: s_data = DW'($urandom);
    endcase
  end

  task automatic do_start(input int b, input int n);
    @(posedge clk); #2;
    start = 1'b1; base_index = IDX_W'(b); num_rows = IDX_W'(n);
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(posedge clk);
      if (!m_active && !m_wr && !m_done) break;
    end
    n_checks++;
    if (i == budget) begin n_fail++; $display("FAIL timeout: job still running after %0d cycles", budget); end
    repeat (2) @(posedge clk);
  endtask

  int w0, e0;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("reset_s_ready", s_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_mem_index", mem_index, 0);
    @(posedge clk); #2 rst = 1'b0;

    // T1 single row, lane k carries k
    data_mode = 1; valid_pct = 100; w0 = wr_count;
    do_start(5, 1);
    wait_idle(1000);
    chk("t1_writes", wr_count - w0, 1);
    chk("t1_index", last_wr_index, 5);
    chk("t1_lane0", last_wr_data[0 +: DW], 0);
    chk("t1_lane7", last_wr_data[7*DW +: DW], 7);
    chk("t1_lane255", last_wr_data[255*DW +: DW], 255);
    chk("t1_wr_latency", wr_cyc - acc_cyc, 256);
    chk("t1_done_after_wr", done_cyc - wr_cyc, 1);

    // T2 multi-row with random backpressure
    data_mode = 0; valid_pct = 50; w0 = wr_count;
    do_start(0, 3);
    wait_idle(5000);
    chk("t2_writes", wr_count - w0, 3);
    chk("t2_last_index", last_wr_index, 2);

    // T3 bounds
    valid_pct = 100; e0 = err_count; w0 = wr_count;
    do_start(930, 9);
    repeat (3) @(posedge clk);
    chk("t3_overrun_err", err_count - e0, 1);
    do_start(7, 0);
    repeat (3) @(posedge clk);
    chk("t3_zero_err", err_count - e0, 2);
    do_start(929, 9);
    wait_idle(5000);
    chk("t3_edge_writes", wr_count - w0, 9);
    chk("t3_edge_last", last_wr_index, 937);

    // T4 abort after 100 beats, then a fresh job must start at lane 0
    data_mode = 0; w0 = wr_count;
    do_start(0, 2);
    for (int i = 0; i < 1000 && m_beats < 100; i++) @(posedge clk);
    #2 abort = 1'b1;
    @(posedge clk); #2 abort = 1'b0;
    repeat (3) @(posedge clk);
    chk("t4_no_write", wr_count - w0, 0);
    data_mode = 1;
    do_start(10, 1);
    wait_idle(1000);
    chk("t4_index", last_wr_index, 10);
    chk("t4_lane0", last_wr_data[0 +: DW], 0);
    chk("t4_lane99", last_wr_data[99*DW +: DW], 99);

    // T5 asynchronous reset between edges mid-FILL
    data_mode = 0;
    do_start(20, 2);
    repeat (50) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("t5_s_ready", s_ready, 0);
    chk("t5_busy", busy, 0);
    chk("t5_index", mem_index, 0);
    chk("t5_data_low", mem_data[63:0], 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    data_mode = 1;
    do_start(3, 1);
    wait_idle(1000);
    chk("t5_after_index", last_wr_index, 3);

    // T6 extreme negative weights
    data_mode = 2;
    do_start(100, 1);
    wait_idle(1000);
    chk("t6_lane255", last_wr_data[3583:3570], 14'h2000);
    chk("t6_lane0", last_wr_data[13:0], 14'h3FFF);

    // random jobs, some of them out of range
    data_mode = 0;
    for (int j = 0; j < 4; j++) begin
      valid_pct = $urandom_range(100, 30);
      do_start($urandom_range(HEIGHT - 1, HEIGHT - 4), $urandom_range(3, 1));
      wait_idle(4000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
